// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with valid/ready flow control.
// Stage 1 prepares operands (zero, then invert); stage 2 computes and
// registers the result together with its zr/ng/co flags.
module hack_alu_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic [CNT_W-1:0] op_count
);

    // Operand preparation: zero first, then bitwise invert (never negate).
    function automatic logic [WIDTH-1:0] prep(input logic [WIDTH-1:0] v,
                                              input logic z, input logic n);
        logic [WIDTH-1:0] a;
        a = z ? '0 : v;
        return n ? ~a : a;
    endfunction

    // Core compute: returns {carry, result}; carry only meaningful for add.
    function automatic logic [WIDTH:0] alu_core(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic fa, input logic na);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] r;
        logic             c;
        if (fa) begin
            sum = {1'b0, a} + {1'b0, b};
            r   = sum[WIDTH-1:0];
            c   = sum[WIDTH];
        end else begin
            r = a & b;
            c = 1'b0;
        end
        if (na) r = ~r;
        return {c, r};
    endfunction

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] xb_p1;
    logic [WIDTH-1:0] yb_p1;
    logic             f_p1;
    logic             no_p1;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH:0]   core;

    // Flow control: stage 2 may load when empty or draining; in_ready never
    // looks at in_valid so upstream can safely wait on it.
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
        accept   = in_valid && in_ready;
        core     = alu_core(xb_p1, yb_p1, f_p1, no_p1);
    end

    assign out_valid = s2_valid;

    // ---- stage 1: operand prep, captured on accept ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            xb_p1    <= '0;
            yb_p1    <= '0;
            f_p1     <= 1'b0;
            no_p1    <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            xb_p1    <= prep(x, zx, nx);
            yb_p1    <= prep(y, zy, ny);
            f_p1     <= f;
            no_p1    <= no;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // ---- stage 2: compute, result and flags registered together ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            zr       <= 1'b0;
            ng       <= 1'b0;
            co       <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            out      <= core[WIDTH-1:0];
            zr       <= (core[WIDTH-1:0] == '0);
            ng       <= core[WIDTH-1];
            co       <= core[WIDTH];
        end else if (s2_valid && out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // Accepted-bundle counter; wraps naturally, ignores output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule
